// File: rtl/eyeriss_pkg.sv
// Shared definitions for the PE controller: parameter defaults, FSM state
// encoding and the job-configuration legality rule.
package eyeriss_pkg;

    localparam int DEF_DATA_SIZE    = 8;
    localparam int DEF_MAC_RES_SIZE = 2 * DEF_DATA_SIZE + 4;
    localparam int DEF_SPAD_DEPTH   = 16;

    typedef enum logic [3:0] {
        IDLE, FILL, LOAD_W, GAP_W, LOAD_A, GAP_A, START, COMPUTE, SUMS, DRAIN, DONE
    } pe_state_e;

    // A job needs at least one weight, no more weights than activations,
    // and all activations must fit in the PE scratchpad.
    function automatic logic cfg_legal(input logic [7:0] wc, input logic [7:0] ac,
                                       input int depth);
        return (wc != 8'd0) && (wc <= ac) && (int'(ac) <= depth);
    endfunction

endpackage

// File: rtl/pe_ctrl_stage_buf.sv
// Staging buffer: appends incoming words, then replays them from index 0.
// Both pointers return to 0 on clr_i so each job starts with an empty buffer.
module pe_ctrl_stage_buf #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clr_i,
    input  logic                 wr_en_i,
    input  logic [DATA_SIZE-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output logic [DATA_SIZE-1:0] rd_data_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][DATA_SIZE-1:0] mem_q;
    logic [AW-1:0]                   wr_ptr_q, rd_ptr_q;

    // Append on write, advance the replay pointer on read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/pe_ctrl.sv
// PE controller: stages a job's weights and activations, streams them into
// the PE, starts the compute, then collects psums into a 2-entry output
// buffer. Define PE_CTRL_PSUM_IN_EN to fold an upstream psum stream into
// every sum cycle; without it the psum_in ports are ignored.
module pe_ctrl
    import eyeriss_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int MAC_RES_SIZE = 2 * DATA_SIZE + 4,
    parameter int SPAD_DEPTH   = DEF_SPAD_DEPTH
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start_i,
    input  logic [7:0]              cfg_acount,
    input  logic [7:0]              cfg_wcount,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [DATA_SIZE-1:0]    w_data_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [DATA_SIZE-1:0]    a_data_i,
    input  logic                    psum_in_valid_i,
    output logic                    psum_in_ready_o,
    input  logic [MAC_RES_SIZE-1:0] psum_in_data_i,
    output logic                    psum_out_valid_o,
    input  logic                    psum_out_ready_i,
    output logic [MAC_RES_SIZE-1:0] psum_out_data_o,
    output logic [DATA_SIZE-1:0]    pe_weights_o,
    output logic [DATA_SIZE-1:0]    pe_acts_o,
    output logic [MAC_RES_SIZE-1:0] pe_psum_o,
    output logic                    pe_loadw_o,
    output logic                    pe_loada_o,
    output logic                    pe_start_o,
    output logic                    pe_sums_o,
    output logic [7:0]              pe_acount_o,
    output logic [7:0]              pe_wcount_o,
    input  logic [MAC_RES_SIZE-1:0] pe_psum_i,
    input  logic                    pe_psum_valid_i,
    input  logic                    pe_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    pe_state_e state_q, state_d;

    logic [7:0] wcount_q, acount_q, wcnt_q, acnt_q, ld_cnt_q;
    logic [8:0] sums_cnt_q, nsums;
    logic       inflight_q, infl_last_q, err_q;

    logic [1:0][MAC_RES_SIZE-1:0] ob_mem_q;
    logic                         ob_wp_q, ob_rp_q;
    logic [1:0]                   ob_cnt_q;

    logic accept, set_err, w_rdy, a_rdy, loadw, loada, start_p, issue;
    logic sum_ok, last_sum, proto_err, push, pop, busy;
    logic [DATA_SIZE-1:0] wbuf_data, abuf_data;

    assign nsums    = {1'b0, acount_q} - {1'b0, wcount_q} + 9'd2;
    assign last_sum = (sums_cnt_q == nsums - 9'd1);

    // Issue a sum only if the psum it produces has a guaranteed slot.
`ifdef PE_CTRL_PSUM_IN_EN
    assign sum_ok          = (ob_cnt_q + {1'b0, inflight_q} < 2'd2) && psum_in_valid_i;
    assign pe_psum_o       = issue ? psum_in_data_i : '0;
    assign psum_in_ready_o = issue;
`else
    logic unused_psum_in;
    assign unused_psum_in  = &{1'b0, psum_in_valid_i, psum_in_data_i};
    assign sum_ok          = (ob_cnt_q + {1'b0, inflight_q} < 2'd2);
    assign pe_psum_o       = '0;
    assign psum_in_ready_o = 1'b0;
`endif

    // PE protocol: every psum answers exactly one issue from the previous
    // cycle, and pe_done_i marks the last one during result collection.
    assign proto_err = (pe_psum_valid_i != inflight_q) ||
                       ((state_q == SUMS || state_q == DRAIN || state_q == DONE) &&
                        (pe_done_i != (inflight_q && pe_psum_valid_i && infl_last_q)));

    assign push = pe_psum_valid_i && inflight_q;
    assign pop  = psum_out_valid_o && psum_out_ready_i;

    // Next-state and per-state control decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        set_err = 1'b0;
        w_rdy   = 1'b0;
        a_rdy   = 1'b0;
        loadw   = 1'b0;
        loada   = 1'b0;
        start_p = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: if (start_i) begin
                if (cfg_legal(cfg_wcount, cfg_acount, SPAD_DEPTH)) begin
                    accept  = 1'b1;
                    state_d = FILL;
                end else begin
                    set_err = 1'b1;
                end
            end
            FILL: begin
                w_rdy = (wcnt_q != wcount_q);
                a_rdy = (acnt_q != acount_q);
                if (!w_rdy && !a_rdy) state_d = LOAD_W;
            end
            LOAD_W: begin
                loadw = 1'b1;
                if (ld_cnt_q == wcount_q - 8'd1) state_d = GAP_W;
            end
            GAP_W:  state_d = LOAD_A;
            LOAD_A: begin
                loada = 1'b1;
                if (ld_cnt_q == acount_q - 8'd1) state_d = GAP_A;
            end
            GAP_A:  state_d = START;
            START: begin
                start_p = 1'b1;
                state_d = COMPUTE;
            end
            COMPUTE: if (pe_done_i) state_d = SUMS;
            SUMS: begin
                issue = sum_ok;
                if (sum_ok && last_sum) state_d = DRAIN;
            end
            DRAIN: if (ob_cnt_q == 2'd0 && !inflight_q) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, job configuration, progress counters and sticky error.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            wcount_q    <= '0;
            acount_q    <= '0;
            wcnt_q      <= '0;
            acnt_q      <= '0;
            ld_cnt_q    <= '0;
            sums_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= (loadw || loada) ? ld_cnt_q + 8'd1 : 8'd0;
            inflight_q  <= issue;
            infl_last_q <= issue && last_sum;
            if (accept) begin
                wcount_q   <= cfg_wcount;
                acount_q   <= cfg_acount;
                wcnt_q     <= '0;
                acnt_q     <= '0;
                sums_cnt_q <= '0;
                err_q      <= 1'b0;
            end else begin
                if (w_valid_i && w_rdy) wcnt_q <= wcnt_q + 8'd1;
                if (a_valid_i && a_rdy) acnt_q <= acnt_q + 8'd1;
                if (issue) sums_cnt_q <= sums_cnt_q + 9'd1;
                if (set_err || proto_err) err_q <= 1'b1;
            end
        end
    end

    // Two-entry psum output FIFO.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ob_mem_q <= '0;
            ob_wp_q  <= 1'b0;
            ob_rp_q  <= 1'b0;
            ob_cnt_q <= '0;
        end else begin
            if (push) begin
                ob_mem_q[ob_wp_q] <= pe_psum_i;
                ob_wp_q           <= ~ob_wp_q;
            end
            if (pop) ob_rp_q <= ~ob_rp_q;
            ob_cnt_q <= ob_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    pe_ctrl_stage_buf #(.DATA_SIZE(DATA_SIZE), .DEPTH(SPAD_DEPTH)) u_wbuf (
        .clk(clk), .nrst(nrst), .clr_i(accept),
        .wr_en_i(w_valid_i && w_rdy), .wr_data_i(w_data_i),
        .rd_en_i(loadw), .rd_data_o(wbuf_data)
    );

    pe_ctrl_stage_buf #(.DATA_SIZE(DATA_SIZE), .DEPTH(SPAD_DEPTH)) u_abuf (
        .clk(clk), .nrst(nrst), .clr_i(accept),
        .wr_en_i(a_valid_i && a_rdy), .wr_data_i(a_data_i),
        .rd_en_i(loada), .rd_data_o(abuf_data)
    );

    assign busy             = (state_q != IDLE);
    assign busy_o           = busy;
    assign done_o           = (state_q == DONE);
    assign err_o            = err_q;
    assign w_ready_o        = w_rdy;
    assign a_ready_o        = a_rdy;
    assign pe_loadw_o       = loadw;
    assign pe_loada_o       = loada;
    assign pe_start_o       = start_p;
    assign pe_sums_o        = issue;
    assign pe_weights_o     = loadw ? wbuf_data : '0;
    assign pe_acts_o        = loada ? abuf_data : '0;
    assign pe_acount_o      = busy ? acount_q : '0;
    assign pe_wcount_o      = busy ? wcount_q : '0;
    assign psum_out_valid_o = (ob_cnt_q != 2'd0);
    assign psum_out_data_o  = ob_mem_q[ob_rp_q];

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed bench for pe_ctrl with a small reactive PE model.
module tb_pe_ctrl;
    localparam int DS = 8;
    localparam int MS = 20;
    localparam int SD = 16;
`ifdef PE_CTRL_PSUM_IN_EN
    localparam int POFF = 100;
`else
    localparam int POFF = 0;
`endif

    logic clk, nrst, start_i;
    logic [7:0] cfg_acount, cfg_wcount;
    logic w_valid_i, w_ready_o, a_valid_i, a_ready_o;
    logic [DS-1:0] w_data_i, a_data_i, pe_weights_o, pe_acts_o;
    logic psum_in_valid_i, psum_in_ready_o, psum_out_valid_o, psum_out_ready_i;
    logic [MS-1:0] psum_in_data_i, psum_out_data_o, pe_psum_o, pe_psum_i;
    logic pe_loadw_o, pe_loada_o, pe_start_o, pe_sums_o, pe_psum_valid_i, pe_done_i;
    logic [7:0] pe_acount_o, pe_wcount_o;
    logic busy_o, done_o, err_o;

    pe_ctrl #(.DATA_SIZE(DS), .MAC_RES_SIZE(MS), .SPAD_DEPTH(SD)) dut (
        .clk(clk), .nrst(nrst), .start_i(start_i),
        .cfg_acount(cfg_acount), .cfg_wcount(cfg_wcount),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .psum_in_valid_i(psum_in_valid_i), .psum_in_ready_o(psum_in_ready_o),
        .psum_in_data_i(psum_in_data_i),
        .psum_out_valid_o(psum_out_valid_o), .psum_out_ready_i(psum_out_ready_i),
        .psum_out_data_o(psum_out_data_o),
        .pe_weights_o(pe_weights_o), .pe_acts_o(pe_acts_o), .pe_psum_o(pe_psum_o),
        .pe_loadw_o(pe_loadw_o), .pe_loada_o(pe_loada_o), .pe_start_o(pe_start_o),
        .pe_sums_o(pe_sums_o), .pe_acount_o(pe_acount_o), .pe_wcount_o(pe_wcount_o),
        .pe_psum_i(pe_psum_i), .pe_psum_valid_i(pe_psum_valid_i), .pe_done_i(pe_done_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus data and hand-computed 1-D convolution results for w=1,2,3, a=1..8.
    logic [7:0] wv[16], av[16];
    int exp_ps[7] = '{14, 20, 26, 32, 38, 44, 23};

    // Job and trace state.
    int job_wc, job_ac, job_ns, rmode, tmo;
    int cyc, loadw_n, loadw_runs, last_loadw, loada_n, loada_runs, first_loada, last_loada;
    int start_n, start_cyc, done_n, full_viol, cfg_viol, pin_viol, b_occ;
    bit prev_w, prev_a;
    logic [7:0] wcap[$], acap[$];
    logic [MS-1:0] got_q[$];

    // PE model state.
    logic [7:0] pw[16], pa[16];
    int pw_n, pa_n, k_iss, cdown, pcyc;
    bit s_sums, s_start;
    logic [MS-1:0] s_pin;

    function automatic logic [MS-1:0] pe_calc(input int k);
        int acc = 0;
        for (int j = 0; j < job_wc; j++)
            if (k + j < job_ac) acc += int'(pw[j]) * int'(pa[k + j]);
        return MS'(acc);
    endfunction

    task automatic clear_trace();
        loadw_n = 0; loadw_runs = 0; last_loadw = -1; loada_n = 0; loada_runs = 0;
        first_loada = -1; last_loada = -1; start_n = 0; start_cyc = -1; done_n = 0;
        full_viol = 0; cfg_viol = 0; pin_viol = 0; b_occ = 0; tmo = 0;
        wcap.delete(); acap.delete(); got_q.delete();
        pw_n = 0; pa_n = 0; k_iss = 0; cdown = 0;
    endtask

    // Monitor: samples on the falling edge.
    initial begin
        cyc = 0; prev_w = 0; prev_a = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pe_loadw_o) begin
                loadw_n++; last_loadw = cyc; wcap.push_back(pe_weights_o);
                if (!prev_w) loadw_runs++;
                if (pw_n < 16) begin pw[pw_n] = pe_weights_o; pw_n++; end
            end
            if (pe_loada_o) begin
                loada_n++; last_loada = cyc; acap.push_back(pe_acts_o);
                if (!prev_a) loada_runs++;
                if (first_loada < 0) first_loada = cyc;
                if (pa_n < 16) begin pa[pa_n] = pe_acts_o; pa_n++; end
            end
            prev_w = pe_loadw_o; prev_a = pe_loada_o;
            if (pe_start_o) begin start_n++; start_cyc = cyc; end
            if (done_o) done_n++;
            if (pe_sums_o && (b_occ + (pe_psum_valid_i ? 1 : 0) >= 2)) full_viol++;
            if (pe_psum_valid_i) b_occ++;
            if (psum_out_valid_o && psum_out_ready_i) begin
                b_occ--; got_q.push_back(psum_out_data_o);
            end
            if (busy_o && (int'(pe_acount_o) != job_ac || int'(pe_wcount_o) != job_wc)) cfg_viol++;
`ifdef PE_CTRL_PSUM_IN_EN
            if (pe_sums_o && !psum_in_valid_i) pin_viol++;
            if (psum_in_ready_o != pe_sums_o) pin_viol++;
`else
            if (pe_psum_o != '0 || psum_in_ready_o) pin_viol++;
`endif
            s_sums = pe_sums_o; s_start = pe_start_o; s_pin = pe_psum_o;
        end
    end

    // PE model, output-ready pattern and upstream psum source.
    initial begin
        pcyc = 0;
        forever begin
            @(posedge clk); #1;
            pcyc++;
            pe_psum_valid_i = 1'b0; pe_done_i = 1'b0;
            if (s_start) cdown = 3;
            else if (cdown > 0) begin
                cdown--;
                if (cdown == 0) pe_done_i = 1'b1;
            end
            if (s_sums) begin
                pe_psum_valid_i = 1'b1;
                pe_psum_i = pe_calc(k_iss) + s_pin;
                k_iss++;
                if (k_iss == job_ns) pe_done_i = 1'b1;
            end
            psum_out_ready_i = (rmode == 0) ? 1'b1 : (pcyc % 3 == 0);
            psum_in_valid_i  = (pcyc % 4 != 0);
            psum_in_data_i   = MS'(100);
        end
    end

    task automatic feed_w(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bit hs = 0;
            w_valid_i = 1'b1; w_data_i = wv[i];
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (w_ready_o) begin hs = 1; break; end
            end
            if (!hs) tmo++;
            @(posedge clk); #1;
            w_valid_i = 1'b0;
            if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        end
    endtask

    task automatic feed_a(input int n);
        for (int i = 0; i < n; i++) begin
            bit hs = 0;
            a_valid_i = 1'b1; a_data_i = av[i];
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (a_ready_o) begin hs = 1; break; end
            end
            if (!hs) tmo++;
            @(posedge clk); #1;
            a_valid_i = 1'b0;
        end
    endtask

    // Start a legal job, poke a stray start while busy, then fill both streams.
    task automatic start_job(input string tag, input int wc, input int ac,
                             input int wgap, input int rm);
        @(negedge clk); #1;
        job_wc = wc; job_ac = ac; job_ns = ac - wc + 2; rmode = rm;
        clear_trace();
        @(posedge clk); #1;
        start_i = 1'b1; cfg_wcount = 8'(wc); cfg_acount = 8'(ac);
        @(posedge clk); #1;
        cfg_wcount = 8'd9; cfg_acount = 8'd1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk({tag, "/err_clr"}, {31'd0, err_o}, 0);
        chk({tag, "/busy"}, {31'd0, busy_o}, 1);
        fork
            feed_w(wc, wgap);
            feed_a(ac);
        join
    endtask

    task automatic finish_job(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_n > 0) break;
        end
        repeat (3) @(negedge clk);
        chk({tag, "/stream_tmo"}, tmo, 0);
        chk({tag, "/loadw_n"}, loadw_n, job_wc);
        chk({tag, "/loadw_runs"}, loadw_runs, 1);
        chk({tag, "/gap_w"}, first_loada - last_loadw, 2);
        chk({tag, "/loada_n"}, loada_n, job_ac);
        chk({tag, "/loada_runs"}, loada_runs, 1);
        chk({tag, "/start_n"}, start_n, 1);
        chk({tag, "/gap_a"}, start_cyc - last_loada, 2);
        chk({tag, "/wcap_n"}, wcap.size(), job_wc);
        for (int i = 0; i < wcap.size() && i < job_wc; i++)
            chk({tag, "/w_order"}, {24'd0, wcap[i]}, {24'd0, wv[i]});
        chk({tag, "/acap_n"}, acap.size(), job_ac);
        for (int i = 0; i < acap.size() && i < job_ac; i++)
            chk({tag, "/a_order"}, {24'd0, acap[i]}, {24'd0, av[i]});
        chk({tag, "/psum_n"}, got_q.size(), 7);
        for (int i = 0; i < got_q.size() && i < 7; i++)
            chk({tag, "/psum"}, 32'(got_q[i]), exp_ps[i] + POFF);
        chk({tag, "/done_n"}, done_n, 1);
        chk({tag, "/full_issue"}, full_viol, 0);
        chk({tag, "/cfg_hold"}, cfg_viol, 0);
        chk({tag, "/psum_in"}, pin_viol, 0);
        chk({tag, "/idle_outs"}, {29'd0, busy_o, err_o, psum_out_valid_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin wv[i] = 8'd0; av[i] = 8'(i + 1); end
        wv[0] = 8'd1; wv[1] = 8'd2; wv[2] = 8'd3;
        nrst = 1'b0; start_i = 1'b0; cfg_acount = '0; cfg_wcount = '0;
        w_valid_i = 1'b0; a_valid_i = 1'b0; w_data_i = '0; a_data_i = '0;
        psum_in_valid_i = 1'b0; psum_in_data_i = '0; psum_out_ready_i = 1'b0;
        pe_psum_i = '0; pe_psum_valid_i = 1'b0; pe_done_i = 1'b0;
        rmode = 0; job_wc = 3; job_ac = 8; job_ns = 7;
        clear_trace();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/ctl", {21'd0, busy_o, done_o, err_o, w_ready_o, a_ready_o,
                          psum_out_valid_o, pe_loadw_o, pe_loada_o, pe_start_o,
                          pe_sums_o, psum_in_ready_o}, 0);
        chk("reset/cnt", {16'd0, pe_acount_o, pe_wcount_o}, 0);
        chk("reset/data", 32'(psum_out_data_o) | 32'(pe_psum_o), 0);
        @(posedge clk); #1;
        nrst = 1'b1;

        start_job("basic", 3, 8, 0, 0);  finish_job("basic");
        start_job("bp",    3, 8, 0, 1);  finish_job("bp");
        start_job("wgap",  3, 8, 5, 0);  finish_job("wgap");

        // Illegal configuration: more weights than activations.
        @(posedge clk); #1;
        start_i = 1'b1; cfg_wcount = 8'd5; cfg_acount = 8'd4;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("illegal/err", {31'd0, err_o}, 1);
        chk("illegal/busy", {31'd0, busy_o}, 0);
        repeat (3) @(negedge clk);
        chk("illegal/hold", {30'd0, err_o, busy_o}, 2);

        start_job("recover", 3, 8, 0, 0);  finish_job("recover");

        // Reset in the middle of LOAD_A.
        start_job("midrst", 3, 8, 0, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (loada_n > 0) break;
        end
        chk("midrst/in_loada", {31'd0, pe_loada_o}, 1);
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("midrst/ctl", {21'd0, busy_o, done_o, err_o, w_ready_o, a_ready_o,
                           psum_out_valid_o, pe_loadw_o, pe_loada_o, pe_start_o,
                           pe_sums_o, psum_in_ready_o}, 0);
        chk("midrst/data", {16'd0, pe_acts_o, pe_acount_o}, 0);
        repeat (2) @(posedge clk); #1;
        nrst = 1'b1;
        start_job("after_rst", 3, 8, 0, 1);  finish_job("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
